// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants for the multi-channel PWM generator
package pwm_pkg;

    // Counting mode of the shared timebase
    localparam logic ALIGN_EDGE   = 1'b0;
    localparam logic ALIGN_CENTER = 1'b1;

    // Count direction in center-aligned mode
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaler, up/up-down counter, committed period/mode and boundary pulse
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      period,
    input  logic                  align,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      cnt,
    output logic [WIDTH-1:0]      period_cur,
    output logic                  boundary,
    output logic                  period_tick
);

    logic [PRESCALE_W-1:0] pcnt;
    logic [PRESCALE_W-1:0] pcnt_nxt;
    logic [WIDTH-1:0]      cnt_nxt;
    logic                  dir;
    logic                  dir_nxt;
    logic                  mode;
    logic                  tick;

    // Tick generation and next counter state; boundary marks the tick that ends a PWM period
    always_comb begin
        tick     = enable && (pcnt >= prescale);
        pcnt_nxt = tick ? '0 : pcnt + 1'b1;
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        if (tick) begin
            if (mode == ALIGN_EDGE) begin
                // A paused period change can leave cnt above P, so wrap on >= rather than ==
                dir_nxt = DIR_UP;
                if (cnt >= period_cur) begin
                    cnt_nxt  = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else if (period_cur == '0) begin
                // Degenerate center period: counter parks at 0, every tick ends a period
                cnt_nxt  = '0;
                dir_nxt  = DIR_UP;
                boundary = 1'b1;
            end else if (dir == DIR_UP) begin
                if (cnt < period_cur) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (period_cur == WIDTH'(1)) begin
                    // P = 1 never visits cnt = 1 on the way down, so the turn is the boundary
                    cnt_nxt  = '0;
                    dir_nxt  = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = period_cur - 1'b1;
                    dir_nxt = DIR_DOWN;
                end
            end else begin
                if (cnt <= WIDTH'(1)) begin
                    cnt_nxt  = '0;
                    dir_nxt  = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            // A mode switch at commit always restarts the count from 0 going up
            if (boundary && (align != mode)) begin
                cnt_nxt = '0;
                dir_nxt = DIR_UP;
            end
        end
    end

    // Counter state, committed period/mode and the registered period_tick pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt        <= '0;
            cnt         <= '0;
            dir         <= DIR_UP;
            period_cur  <= '0;
            mode        <= ALIGN_EDGE;
            period_tick <= 1'b0;
        end else begin
            if (enable) begin
                pcnt <= pcnt_nxt;
                cnt  <= cnt_nxt;
                dir  <= dir_nxt;
            end
            // While paused the settings track live so a resume starts with them
            if (boundary || !enable) begin
                period_cur <= period;
                mode       <= align;
            end
            period_tick <= boundary;
        end
    end

    logic unused_center;
    assign unused_center = (mode == ALIGN_CENTER);

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM generator with double-buffered duty and shared timebase
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      period,
    input  logic                  align,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [CHANNELS-1:0]   invert,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [WIDTH-1:0]      wr_duty,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_tick
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] period_cur;
    logic             boundary;
    logic             commit;

    pwm_timebase #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .period      (period),
        .align       (align),
        .prescale    (prescale),
        .cnt         (cnt),
        .period_cur  (period_cur),
        .boundary    (boundary),
        .period_tick (period_tick)
    );

    // Active duties reload at each period boundary, and continuously while paused
    assign commit = boundary || !enable;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] shadow_q;
        logic [WIDTH-1:0] active_q;
        logic             wr_hit;
        logic             raw;
        logic             out_q;

        // Out-of-range channel numbers match no decode and are dropped
        assign wr_hit = wr_en && (wr_ch == CH_W'(i));

        // Duty >= P saturates to 100 %, so full-scale duty at full-scale period stays high
        assign raw = (cnt < active_q) || (active_q >= period_cur);

        // Shadow takes writes at once; active loads at commit with same-cycle write-through
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_q <= '0;
                active_q <= '0;
            end else begin
                if (wr_hit) begin
                    shadow_q <= wr_duty;
                end
                if (commit) begin
                    active_q <= wr_hit ? wr_duty : shadow_q;
                end
            end
        end

        // Registered output, forced low while paused regardless of inversion
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q <= 1'b0;
            end else begin
                out_q <= enable && (raw ^ invert[i]);
            end
        end

        assign pwm_out[i] = out_q;
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - self-checking bench for pwm_multi
module tb_pwm_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] period = 8'd0;
    logic       align = 1'b0;
    logic [7:0] prescale = 8'd0;
    logic [2:0] invert = 3'b000;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = 2'd0;
    logic [7:0] wr_duty = 8'd0;
    logic [2:0] pwm_out;
    logic       period_tick;

    int checks = 0;
    int failures = 0;

    pwm_multi #(
        .WIDTH      (8),
        .CHANNELS   (3),
        .PRESCALE_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .period      (period),
        .align       (align),
        .prescale    (prescale),
        .invert      (invert),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       p;
        bit       al;
        int       pre;
        bit [2:0] inv;
        int       ch;
        int       duty;
        int       exp_len;
        int       exp_high;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        wr_en  = 1'b0;
        invert = 3'b000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_duty(input int ch, input int duty);
        wr_en   = 1'b1;
        wr_ch   = ch[1:0];
        wr_duty = duty[7:0];
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic setup(input int p, input bit al, input int pre, input bit [2:0] inv,
                         input int ch, input int duty);
        do_reset();
        period   = p[7:0];
        align    = al;
        prescale = pre[7:0];
        invert   = inv;
        write_duty(ch, duty);
        @(negedge clk);
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (period_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called on the sample where period_tick is high; counts up to the next one.
    // wr_at > 0 issues a duty write to ch after that many samples of the window.
    task automatic window(input int ch, input int wr_at, input int wr_val,
                          output int len, output int high, output int rises, output bit ok);
        logic prev;
        len   = 1;
        high  = pwm_out[ch] ? 1 : 0;
        prev  = pwm_out[ch];
        rises = 0;
        ok    = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (len == wr_at) begin
                wr_en   = 1'b1;
                wr_ch   = ch[1:0];
                wr_duty = wr_val[7:0];
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            if (period_tick) begin
                ok = 1'b1;
                break;
            end
            len++;
            if (pwm_out[ch]) high++;
            if (pwm_out[ch] && !prev) rises++;
            prev = pwm_out[ch];
        end
        wr_en = 1'b0;
    endtask

    initial begin
        bit ok;
        int len, high, rises, high1, bad;
        bit paused;

        // period, align, prescale, invert, channel, duty, window clocks, high clocks
        vecs[0] = '{255, 1'b0, 0, 3'b000, 0, 64,  256, 64};
        vecs[1] = '{9,   1'b0, 0, 3'b000, 0, 3,   10,  3};
        vecs[2] = '{10,  1'b1, 0, 3'b000, 0, 4,   20,  7};
        vecs[3] = '{255, 1'b0, 0, 3'b000, 0, 255, 256, 256};
        vecs[4] = '{255, 1'b0, 0, 3'b000, 0, 0,   256, 0};
        vecs[5] = '{255, 1'b0, 0, 3'b001, 0, 0,   256, 256};
        vecs[6] = '{7,   1'b0, 3, 3'b000, 0, 2,   32,  8};
        vecs[7] = '{10,  1'b1, 0, 3'b000, 1, 10,  20,  20};
        vecs[8] = '{5,   1'b0, 0, 3'b000, 2, 7,   6,   6};
        vecs[9] = '{10,  1'b1, 0, 3'b100, 2, 4,   20,  13};

        // Reset state
        @(negedge clk);
        chk("reset_pwm_out", int'(pwm_out), 0);
        chk("reset_period_tick", int'(period_tick), 0);

        // Table-driven steady-state periods
        for (int v = 0; v < 10; v++) begin
            setup(vecs[v].p, vecs[v].al, vecs[v].pre, vecs[v].inv, vecs[v].ch, vecs[v].duty);
            chk($sformatf("vec%0d_disabled_out", v), int'(pwm_out), 0);
            enable = 1'b1;
            wait_tick(ok);
            chk($sformatf("vec%0d_first_tick", v), int'(ok), 1);
            if (ok) begin
                window(vecs[v].ch, 0, 0, len, high, rises, ok);
                chk($sformatf("vec%0d_window_tick", v), int'(ok), 1);
                chk($sformatf("vec%0d_len", v), len, vecs[v].exp_len);
                chk($sformatf("vec%0d_high", v), high, vecs[v].exp_high);
            end
        end

        // Boundary commit: mid-period write waits, boundary-cycle write goes through
        setup(9, 1'b0, 0, 3'b000, 0, 3);
        enable = 1'b1;
        wait_tick(ok);
        chk("commit_first_tick", int'(ok), 1);
        window(0, 4, 7, len, high, rises, ok);
        chk("commit_old_len", len, 10);
        chk("commit_old_high", high, 3);
        chk("commit_old_rises", rises, 1);
        window(0, 10, 6, len, high, rises, ok);
        chk("commit_new_len", len, 10);
        chk("commit_new_high", high, 7);
        chk("commit_new_rises", rises, 1);
        window(0, 0, 0, len, high, rises, ok);
        chk("commit_writethru_high", high, 6);

        // Out-of-range channel write leaves every shadow untouched
        do_reset();
        period = 8'd9;
        align = 1'b0;
        prescale = 8'd0;
        write_duty(0, 2);
        write_duty(1, 5);
        write_duty(2, 8);
        write_duty(3, 1);
        enable = 1'b1;
        wait_tick(ok);
        chk("wrch_first_tick", int'(ok), 1);
        window(0, 0, 0, len, high, rises, ok);
        chk("wrch_ch0_high", high, 2);
        window(1, 0, 0, len, high, rises, ok);
        chk("wrch_ch1_high", high, 5);
        window(2, 0, 0, len, high, rises, ok);
        chk("wrch_ch2_high", high, 8);

        // Pause mid-period: outputs drop at once, counter resumes where it held
        setup(7, 1'b0, 3, 3'b000, 0, 2);
        enable = 1'b1;
        wait_tick(ok);
        chk("pause_first_tick", int'(ok), 1);
        len = 1;
        high = pwm_out[0] ? 1 : 0;
        bad = 0;
        paused = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (len == 4 && !paused) begin
                paused = 1'b1;
                chk("pause_pre_high", int'(pwm_out[0]), 1);
                enable = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    if (pwm_out != 3'b000 || period_tick) bad++;
                end
                enable = 1'b1;
            end
            @(negedge clk);
            if (period_tick) begin
                ok = 1'b1;
                break;
            end
            len++;
            if (pwm_out[0]) high++;
        end
        chk("pause_window_tick", int'(ok), 1);
        chk("pause_outputs_low", bad, 0);
        chk("pause_len", len, 32);
        chk("pause_high", high, 8);

        // Asynchronous reset between edges at cnt = 150
        setup(255, 1'b0, 0, 3'b000, 0, 200);
        enable = 1'b1;
        wait_tick(ok);
        chk("areset_first_tick", int'(ok), 1);
        repeat (150) @(negedge clk);
        chk("areset_pre_high", int'(pwm_out[0]), 1);
        #2;
        rst = 1'b1;
        enable = 1'b0;
        #1;
        chk("areset_out_before_edge", int'(pwm_out), 0);
        chk("areset_tick_before_edge", int'(period_tick), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        write_duty(1, 100);
        @(negedge clk);
        enable = 1'b1;
        len = 0;
        high = 0;
        high1 = 0;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            len++;
            if (pwm_out[0]) high++;
            if (pwm_out[1]) high1++;
            if (period_tick) begin
                ok = 1'b1;
                break;
            end
        end
        chk("areset_period_tick", int'(ok), 1);
        chk("areset_first_len", len, 256);
        chk("areset_ch0_cleared", high, 0);
        chk("areset_ch1_high", high1, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
